// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv-output max-pool stage.
//   pix_t        : signed fixed-point pixel at the default 8-bit width
//   pool_state_e : row-phase of the pooling FSM (even row / odd row / dropped tail row)
//   ceil(x, y)   : x rounded up to the next multiple of y (used to pad row width)
package conv_pkg;

  localparam int PIX_W_DEF = 8;

  typedef logic signed [PIX_W_DEF-1:0] pix_t;

  typedef enum logic [1:0] {
    S_EVEN,
    S_ODD,
    S_TAIL
  } pool_state_e;

  function automatic int ceil(input int x, input int y);
    return ((x + y - 1) / y) * y;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer holding the horizontally-maxed even row, one entry per segment.
// Ports:
//   clk   : rising-edge clock
//   we    : write strobe (even-row beat consumed)
//   waddr : segment index being written
//   wdata : horizontally pooled half-beat
//   raddr : segment index being read
//   rdata : stored half-beat, combinational read so the odd row pools in the
//           same cycle its beat is consumed
module pool_line_buf #(
  parameter int DEPTH  = 2,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  // No reset: contents are always rewritten by an even row before being read.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/conv_out_maxpool2x2.sv
// Streaming 2x2 / stride-2 max-pool stage fed by the PE output FIFO array.
// Even rows are reduced horizontally and parked in a line buffer; each odd-row
// beat is reduced horizontally, maxed against the parked segment and emitted.
// Ports:
//   clk                     : rising-edge clock
//   rstn                    : synchronous reset, active-high (1 = reset)
//   fifo_array1_dataout     : FWFT head beat, LANES pixels of one row
//   pe2row_data_valid       : head beat is valid
//   pe2row_fifo_array1_rden : pop strobe for the head beat
//   pe2row_ready            : stage can take a beat this cycle
//   pool_data               : LANES/2 pooled pixels
//   pool_valid / pool_ready : output handshake
//   pool_rcc                : {channel, pooled row, segment} tag
//   frame_done              : pulse after the last beat of channel C-1 is accepted
module conv_out_maxpool2x2
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRECISION  = 4,
  parameter int LANES      = 8,
  parameter int REAL_W     = 56,
  parameter int REAL_H     = 56,
  parameter int C          = 256,
  parameter int RELU       = 0,
  parameter int ROW_WIDTH  = 10
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic [LANES-1:0][DATA_WIDTH-1:0]      fifo_array1_dataout,
  input  logic                                  pe2row_data_valid,
  output logic                                  pe2row_fifo_array1_rden,
  output logic                                  pe2row_ready,
  output logic [LANES/2-1:0][DATA_WIDTH-1:0]    pool_data,
  output logic                                  pool_valid,
  input  logic                                  pool_ready,
  output logic [2:0][ROW_WIDTH-1:0]             pool_rcc,
  output logic                                  frame_done
);

  localparam int W     = ceil(REAL_W, LANES);
  localparam int SEGS  = W / LANES;
  localparam int HL    = LANES / 2;
  localparam int PH    = REAL_H / 2;
  localparam int SEG_W = (SEGS > 1) ? $clog2(SEGS) : 1;
  localparam int ROW_W = (REAL_H > 1) ? $clog2(REAL_H) : 1;
  localparam int CH_W  = (C > 1) ? $clog2(C) : 1;

  // Fraction bits ride along untouched; only sanity-check the configuration.
  if (PRECISION > DATA_WIDTH || (LANES % 2) != 0) begin : g_param_check
    $error("conv_out_maxpool2x2: bad PRECISION/LANES configuration");
  end

  pool_state_e             state_reg;
  logic [SEG_W-1:0]        seg_reg;
  logic [ROW_W-1:0]        row_reg;
  logic [CH_W-1:0]         ch_reg;
  logic                    pool_last_reg;

  logic                    consume;
  logic                    seg_last;
  logic                    row_last;
  logic                    ch_last;
  logic                    next_is_tail;
  logic [HL-1:0][DATA_WIDTH-1:0] hm;
  logic [HL-1:0][DATA_WIDTH-1:0] lb_rd;
  logic [HL-1:0][DATA_WIDTH-1:0] pool_next;

  // Single output register: a held output blocks input, an accepted one frees it
  // in the same cycle so a full-rate stream sees no bubble.
  assign pe2row_ready            = ~pool_valid | pool_ready;
  assign consume                 = pe2row_data_valid & pe2row_ready;
  assign pe2row_fifo_array1_rden = consume;

  assign seg_last = (seg_reg == SEG_W'(SEGS - 1));
  assign row_last = (row_reg == ROW_W'(REAL_H - 1));
  assign ch_last  = (ch_reg == CH_W'(C - 1));
  // After the last odd row of an odd-height channel one unpaired row remains.
  assign next_is_tail = ((REAL_H % 2) == 1) && (row_reg == ROW_W'(REAL_H - 2));

  for (genvar gi = 0; gi < HL; gi++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] a;
    logic signed [DATA_WIDTH-1:0] b;
    logic signed [DATA_WIDTH-1:0] h;
    logic signed [DATA_WIDTH-1:0] up;
    logic signed [DATA_WIDTH-1:0] m;
    assign a  = fifo_array1_dataout[2*gi];
    assign b  = fifo_array1_dataout[2*gi+1];
    assign h  = (a > b) ? a : b;
    assign up = lb_rd[gi];
    assign m  = (h > up) ? h : up;
    assign hm[gi]        = h;
    assign pool_next[gi] = ((RELU != 0) && (m < 0)) ? '0 : m;
  end

  pool_line_buf #(
    .DEPTH  (SEGS),
    .WIDTH  (HL * DATA_WIDTH),
    .ADDR_W (SEG_W)
  ) u_line_buf (
    .clk   (clk),
    .we    (consume && (state_reg == S_EVEN)),
    .waddr (seg_reg),
    .wdata (hm),
    .raddr (seg_reg),
    .rdata (lb_rd)
  );

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_reg     <= S_EVEN;
      seg_reg       <= '0;
      row_reg       <= '0;
      ch_reg        <= '0;
      pool_valid    <= 1'b0;
      pool_data     <= '0;
      pool_rcc      <= '0;
      pool_last_reg <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= pool_valid & pool_ready & pool_last_reg;
      if (pool_valid & pool_ready) begin
        pool_valid <= 1'b0;
      end
      if (consume) begin
        // An odd-row beat reloads the output register (overrides the clear above).
        if (state_reg == S_ODD) begin
          pool_valid    <= 1'b1;
          pool_data     <= pool_next;
          pool_rcc      <= {ROW_WIDTH'(ch_reg), ROW_WIDTH'(row_reg >> 1), ROW_WIDTH'(seg_reg)};
          pool_last_reg <= ch_last & seg_last & (row_reg == ROW_W'(2 * PH - 1));
        end
        if (seg_last) begin
          seg_reg <= '0;
          if (row_last) begin
            row_reg <= '0;
            ch_reg  <= ch_last ? '0 : ch_reg + 1'b1;
          end else begin
            row_reg <= row_reg + 1'b1;
          end
          case (state_reg)
            S_EVEN:  state_reg <= S_ODD;
            S_ODD:   state_reg <= next_is_tail ? S_TAIL : S_EVEN;
            default: state_reg <= S_EVEN;
          endcase
        end else begin
          seg_reg <= seg_reg + 1'b1;
        end
      end
    end
  end

endmodule
